// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage between execute and signext.
// Accepts one load/store at a time, runs it over a valid/ready memory port,
// and returns the right-aligned, size-masked load value together with the
// signext operation code and an error code.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake (ready only in idle)
//   req_is_store, req_funct3      access kind (RV32I funct3 encoding)
//   req_addr, req_wdata           byte address, right-aligned store data
//   mem_valid / mem_ready         memory request handshake
//   mem_we, mem_addr              write enable, word-aligned address
//   mem_wdata, mem_wstrb          lane-shifted store data, byte strobes
//   mem_rvalid, mem_rdata         read data return
//   resp_valid                    one-cycle completion pulse
//   resp_data                     load value shifted down and masked to size
//   resp_sx_op                    code for signext
//   resp_err                      00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
module load_store_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [4:0]            resp_sx_op,
  output logic [1:0]            resp_err
);

  // signext operation codes shared with the ISA package
  localparam logic [4:0] SX_0700  = 5'h01;
  localparam logic [4:0] SX_1500  = 5'h02;
  localparam logic [4:0] SX_3100  = 5'h03;
  localparam logic [4:0] SXU_0700 = 5'h04;
  localparam logic [4:0] SXU_1500 = 5'h05;

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrIllegal  = 2'b10;
  localparam logic [1:0] ErrTimeout  = 2'b11;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [7:0] TimeoutCnt = TIMEOUT_CYCLES[7:0];

  logic [1:0]            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            err_q, err_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [4:0]            resp_sx_op_q, resp_sx_op_d;
  logic [1:0]            resp_err_q, resp_err_d;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic [4:0]            lane_shift;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_data;
  logic [3:0]            store_strb;
  logic [4:0]            sx_op;

  // Request decode on the incoming (not yet latched) request.
  always_comb begin
    if (req_is_store) begin
      req_illegal = (req_funct3 >= 3'b011);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
    unique case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign lane_shift = {addr_q[1:0], 3'b000};

  // Lane steering and size masking for the latched access.
  always_comb begin
    load_data  = mem_rdata >> lane_shift;
    store_data = req_wdata_zero();
    store_strb = 4'b0000;
    unique case (funct3_q[1:0])
      2'b00: begin
        load_data  = load_data & DATA_WIDTH'(32'h0000_00FF);
        store_data = DATA_WIDTH'({24'h0, wdata_q[7:0]}) << lane_shift;
        store_strb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        load_data  = load_data & DATA_WIDTH'(32'h0000_FFFF);
        store_data = DATA_WIDTH'({16'h0, wdata_q[15:0]}) << lane_shift;
        store_strb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        store_data = wdata_q;
        store_strb = 4'b1111;
      end
    endcase
  end

  function automatic logic [DATA_WIDTH-1:0] req_wdata_zero();
    return '0;
  endfunction

  always_comb begin
    sx_op = SX_3100;
    if (!is_store_q && (err_q == ErrOk)) begin
      unique case (funct3_q)
        3'b000:  sx_op = SX_0700;
        3'b001:  sx_op = SX_1500;
        3'b100:  sx_op = SXU_0700;
        3'b101:  sx_op = SXU_1500;
        default: sx_op = SX_3100;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_sx_op_d = resp_sx_op_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          cnt_d      = 8'd0;
          data_d     = '0;
          if (req_illegal) begin
            err_d   = ErrIllegal;
            state_d = StResp;
          end else if (req_misaligned) begin
            err_d   = ErrMisalign;
            state_d = StResp;
          end else begin
            err_d   = ErrOk;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          state_d = is_store_q ? StResp : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          data_d  = load_data;
          state_d = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          err_d   = ErrTimeout;
          data_d  = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        // Response outputs are registered here so they hold until the next access completes.
        resp_valid_d = 1'b1;
        resp_data_d  = data_q;
        resp_sx_op_d = sx_op;
        resp_err_d   = err_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 8'd0;
      data_q       <= '0;
      err_q        <= ErrOk;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_sx_op_q <= 5'd0;
      resp_err_q   <= ErrOk;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_sx_op_q <= resp_sx_op_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory port is only driven while a request is outstanding.
  always_comb begin
    req_ready = (state_q == StIdle);
    mem_valid = (state_q == StReq);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    if (state_q == StReq) begin
      mem_we   = is_store_q;
      mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      if (is_store_q) begin
        mem_wdata = store_data;
        mem_wstrb = store_strb;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_sx_op = resp_sx_op_q;
  assign resp_err   = resp_err_q;

endmodule
